// File: rtl/sync_ram_port_if.sv
// rtl/sync_ram_port_if.sv - access bus between a requester and the synchronous RAM port
interface sync_ram_port_if #(
    parameter int depth = 16,
    parameter int width = 8
);
    logic [depth-1:0]   addr;
    logic               enable_x;
    logic               write_x;
    logic [width/8-1:0] mask;
    logic [width-1:0]   wdata;
    logic [width-1:0]   rdata;
    logic               valid;
    logic               ready;

    modport master (
        output addr, enable_x, write_x, mask, wdata,
        input  rdata, valid, ready
    );

    modport slave (
        input  addr, enable_x, write_x, mask, wdata,
        output rdata, valid, ready
    );
endinterface

// File: rtl/sync_ram_port.sv
// rtl/sync_ram_port.sv - single-port RAM with lane mask, 1/2-clock read latency and reset clear sweep
module sync_ram_port #(
    parameter int depth          = 16,
    parameter int width          = 8,
    parameter int latency        = 1,
    parameter int write_first    = 0,
    parameter int clear_on_reset = 1
) (
    input  logic            clk,
    input  logic            rst,
    sync_ram_port_if.slave  bus
);
    localparam int lanes = width / 8;

    generate
        if ((width % 8) != 0 || (latency != 1 && latency != 2)) begin : g_bad_params
            $error("sync_ram_port: width must be a multiple of 8 and latency 1 or 2");
        end
    endgenerate

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [depth-1:0] cnt;
    logic [depth-1:0] cnt_next;
    logic             ready;
    logic             ready_next;
    logic             clear_we;

    logic [width-1:0] mem [2**depth];
    logic [width-1:0] old_word;
    logic [width-1:0] merged;
    logic [width-1:0] resp;
    logic             accept;
    logic             wr_accept;

    logic [width-1:0] data_s1;
    logic             valid_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (clear_on_reset != 0) ? CLEAR : RUN;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_next = ready;
        clear_we   = 1'b0;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                cnt_next = cnt + 1'b1;
                // Last word written this edge: leave the sweep without wrapping.
                if (cnt == {depth{1'b1}}) begin
                    state_next = RUN;
                    ready_next = 1'b1;
                end
            end
            RUN: begin
                ready_next = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign accept    = ready && !bus.enable_x;
    assign wr_accept = accept && !bus.write_x;
    assign old_word  = mem[bus.addr];

    always_comb begin
        merged = old_word;
        for (int k = 0; k < lanes; k++) begin
            if (bus.mask[k]) begin
                merged[8*k +: 8] = bus.wdata[8*k +: 8];
            end
        end
    end

    // Reads always see the stored word; writes return old or merged word by mode.
    assign resp = (wr_accept && write_first != 0) ? merged : old_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clear_we) begin
                mem[cnt] <= '0;
            end else if (wr_accept) begin
                mem[bus.addr] <= merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_s1  <= '0;
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= accept;
            if (accept) begin
                data_s1 <= resp;
            end
        end
    end

    generate
        if (latency == 2) begin : g_lat2
            logic [width-1:0] data_s2;
            logic             valid_s2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_s2  <= '0;
                    valid_s2 <= 1'b0;
                end else begin
                    valid_s2 <= valid_s1;
                    if (valid_s1) begin
                        data_s2 <= data_s1;
                    end
                end
            end

            assign bus.rdata = data_s2;
            assign bus.valid = valid_s2;
        end else begin : g_lat1
            assign bus.rdata = data_s1;
            assign bus.valid = valid_s1;
        end
    endgenerate

    assign bus.ready = ready;
endmodule
